// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO test-harness controller: bus widths, register
// offsets, magic values, response codes and the address decoder.
package mmio_pkg;

  localparam int BUS_WIDTH      = 32;
  localparam int BUS_RESP_WIDTH = 2;

  localparam logic [11:0] OFF_TEST        = 12'h000;
  localparam logic [11:0] OFF_UART_TX     = 12'h004;
  localparam logic [11:0] OFF_UART_STATUS = 12'h040;
  localparam logic [11:0] OFF_SYSCALL     = 12'h080;

  localparam logic [31:0] PASS_CODE     = 32'h0100_0001;
  localparam logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b10;

  typedef enum logic [2:0] {
    REG_NONE, REG_TEST, REG_UART, REG_STATUS, REG_SYSCALL
  } reg_e;

  typedef struct packed {
    reg_e       kind;
    logic [2:0] chan;
  } dec_t;

  // Window is 4 KiB aligned, so the upper address bits select it directly.
  function automatic dec_t decode(input logic [31:0] addr, input logic [31:0] base,
                                  input int nch);
    dec_t       d;
    logic [11:0] off;
    d.kind = REG_NONE;
    d.chan = '0;
    off    = addr[11:0];
    if (addr[31:12] == base[31:12]) begin
      if (off == OFF_TEST)                d.kind = REG_TEST;
      else if (off == OFF_UART_STATUS)    d.kind = REG_STATUS;
      else if (off == OFF_SYSCALL)        d.kind = REG_SYSCALL;
      else if (off[1:0] == 2'b00 && off >= OFF_UART_TX &&
               off < OFF_UART_TX + 12'(4 * nch)) begin
        d.kind = REG_UART;
        d.chan = 3'(off[11:2] - 10'd1);
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/mmio_fifo.sv
// Per-channel TX byte FIFO; pointers carry one extra wrap bit so full and
// empty are distinguished without a counter.
module mmio_fifo
  import mmio_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr, rptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push && !full) begin
        mem[wptr[AW-1:0]] <= din;
        wptr              <= wptr + 1'b1;
      end
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/mmio_ctrl.sv
// MMIO register window for simulation harnesses: TEST flag, UART TX FIFOs,
// UART status and an optional SYSCALL register (enabled by MMIO_SYSCALL_EN).
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h8000,
  parameter int          UART_CHANNELS = 1,
  parameter int          FIFO_DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dw_data_addr_valid,
  output logic                       dw_data_addr_ready,
  input  logic [BUS_WIDTH-1:0]       dw_addr,
  input  logic [BUS_WIDTH-1:0]       dw_data,
  input  logic [BUS_WIDTH/8-1:0]     dw_strobe,
  output logic                       dw_resp_valid,
  input  logic                       dw_resp_ready,
  output logic [BUS_RESP_WIDTH-1:0]  dw_resp,
  input  logic                       dr_addr_valid,
  output logic                       dr_addr_ready,
  input  logic [BUS_WIDTH-1:0]       dr_addr,
  output logic                       dr_data_valid,
  input  logic                       dr_data_ready,
  output logic [BUS_WIDTH-1:0]       dr_data,
  output logic                       test_done,
  output logic                       test_pass,
  output logic [UART_CHANNELS-1:0]   uart_tx_valid,
  input  logic [UART_CHANNELS-1:0]   uart_tx_ready,
  output logic [8*UART_CHANNELS-1:0] uart_tx_data,
  input  logic [BUS_WIDTH-1:0]       syscall_in
);

  logic                     up;
  dec_t                     wdec, rdec;
  logic [UART_CHANNELS-1:0] uart_hit, push, pop, empty, full;
  logic                     w_acc, r_acc, w_full;
  logic [1:0]               w_resp;
  logic [31:0]              status, rdata;
  logic                     unused_bits;

  assign wdec = decode(dw_addr, BASE_ADDR, UART_CHANNELS);
  assign rdec = decode(dr_addr, BASE_ADDR, UART_CHANNELS);

  always_comb begin
    uart_hit = '0;
    for (int k = 0; k < UART_CHANNELS; k++)
      uart_hit[k] = (wdec.kind == REG_UART) && (wdec.chan == 3'(k));
  end

  // A UART write to a full FIFO stalls rather than dropping the byte.
  assign w_full             = |(uart_hit & full);
  assign dw_data_addr_ready = up && !dw_resp_valid && !w_full;
  assign dr_addr_ready      = up && !dr_data_valid;
  assign w_acc              = dw_data_addr_valid && dw_data_addr_ready;
  assign r_acc              = dr_addr_valid && dr_addr_ready;

  assign push          = uart_hit & {UART_CHANNELS{w_acc && dw_strobe[0]}};
  assign uart_tx_valid = ~empty;
  assign pop           = uart_tx_valid & uart_tx_ready;
  assign w_resp        = (wdec.kind == REG_TEST || wdec.kind == REG_UART) ? RESP_OKAY
                                                                          : RESP_ERROR;

  for (genvar k = 0; k < UART_CHANNELS; k++) begin : g_ch
    mmio_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[k]),
      .pop   (pop[k]),
      .din   (dw_data[7:0]),
      .dout  (uart_tx_data[8*k +: 8]),
      .empty (empty[k]),
      .full  (full[k])
    );
  end

  always_comb begin
    status                    = '0;
    status[0 +: UART_CHANNELS] = empty;
    status[8 +: UART_CHANNELS] = full;
  end

  always_comb begin
    rdata = UNMAPPED_DATA;
    case (rdec.kind)
      REG_STATUS:  rdata = status;
`ifdef MMIO_SYSCALL_EN
      REG_SYSCALL: rdata = syscall_in;
`endif
      default:     rdata = UNMAPPED_DATA;
    endcase
  end

`ifdef MMIO_SYSCALL_EN
  assign unused_bits = ^dw_strobe[BUS_WIDTH/8-1:1];
`else
  assign unused_bits = ^{dw_strobe[BUS_WIDTH/8-1:1], syscall_in};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up            <= 1'b0;
      dw_resp_valid <= 1'b0;
      dw_resp       <= '0;
      dr_data_valid <= 1'b0;
      dr_data       <= '0;
      test_done     <= 1'b0;
      test_pass     <= 1'b0;
    end else begin
      up <= 1'b1;
      if (w_acc) begin
        dw_resp_valid <= 1'b1;
        dw_resp       <= w_resp;
      end else if (dw_resp_ready) begin
        dw_resp_valid <= 1'b0;
      end
      // First TEST write decides the verdict; later ones are acknowledged only.
      if (w_acc && wdec.kind == REG_TEST && !test_done) begin
        test_done <= 1'b1;
        test_pass <= (dw_data == PASS_CODE);
      end
      if (r_acc) begin
        dr_data_valid <= 1'b1;
        dr_data       <= rdata;
      end else if (dr_data_ready) begin
        dr_data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mmio_ctrl.sv
// Bench for mmio_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based model.
module tb_mmio_ctrl;

  localparam int          N     = 1;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h8000;
`ifdef MMIO_SYSCALL_EN
  localparam bit SYS_EN = 1'b1;
`else
  localparam bit SYS_EN = 1'b0;
`endif

  logic          clk = 1'b0, rst = 1'b0;
  logic          dw_data_addr_valid = 0, dw_data_addr_ready;
  logic [31:0]   dw_addr = 0, dw_data = 0;
  logic [3:0]    dw_strobe = 0;
  logic          dw_resp_valid, dw_resp_ready = 0;
  logic [1:0]    dw_resp;
  logic          dr_addr_valid = 0, dr_addr_ready;
  logic [31:0]   dr_addr = 0;
  logic          dr_data_valid, dr_data_ready = 0;
  logic [31:0]   dr_data;
  logic          test_done, test_pass;
  logic [N-1:0]  uart_tx_valid, uart_tx_ready = '0;
  logic [8*N-1:0] uart_tx_data;
  logic [31:0]   syscall_in = 0;

  mmio_ctrl #(.BASE_ADDR(BASE), .UART_CHANNELS(N), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .dw_data_addr_valid(dw_data_addr_valid), .dw_data_addr_ready(dw_data_addr_ready),
    .dw_addr(dw_addr), .dw_data(dw_data), .dw_strobe(dw_strobe),
    .dw_resp_valid(dw_resp_valid), .dw_resp_ready(dw_resp_ready), .dw_resp(dw_resp),
    .dr_addr_valid(dr_addr_valid), .dr_addr_ready(dr_addr_ready), .dr_addr(dr_addr),
    .dr_data_valid(dr_data_valid), .dr_data_ready(dr_data_ready), .dr_data(dr_data),
    .test_done(test_done), .test_pass(test_pass),
    .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready), .uart_tx_data(uart_tx_data),
    .syscall_in(syscall_in)
  );

  always #5 clk = ~clk;

  int total = 0, passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  q[N][$];
  bit          m_up, m_wv, m_rv, m_done, m_pass;
  logic [1:0]  m_resp;
  logic [31:0] m_rdata;

  function automatic int offset(input logic [31:0] a);
    return int'(a) - int'(BASE);
  endfunction

  function automatic int uart_chan(input logic [31:0] a);
    int off = offset(a);
    if (off >= 4 && off < 4 + 4 * N && off % 4 == 0) return (off - 4) / 4;
    return -1;
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s = '0;
    for (int k = 0; k < N; k++) begin
      if (q[k].size() == 0)     s[k]     = 1'b1;
      if (q[k].size() == DEPTH) s[8 + k] = 1'b1;
    end
    return s;
  endfunction

  function automatic logic [31:0] read_value(input logic [31:0] a);
    int off = offset(a);
    if (off == 32'h40) return m_status();
    if (off == 32'h80 && SYS_EN) return syscall_in;
    return 32'hDEADBEEF;
  endfunction

  function automatic bit m_wready();
    int c = uart_chan(dw_addr);
    return m_up && !m_wv && !(c >= 0 && q[c].size() == DEPTH);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) q[k].delete();
    m_up = 0; m_wv = 0; m_rv = 0; m_done = 0; m_pass = 0; m_resp = 0; m_rdata = 0;
  endtask

  task automatic model_step();
    bit wa, ra;
    int c;
    logic [31:0] rv;
    wa = dw_data_addr_valid && m_wready();
    ra = dr_addr_valid && m_up && !m_rv;
    rv = read_value(dr_addr);
    for (int k = 0; k < N; k++)
      if (uart_tx_ready[k] && q[k].size() > 0) void'(q[k].pop_front());
    if (m_wv && dw_resp_ready) m_wv = 0;
    if (wa) begin
      c    = uart_chan(dw_addr);
      m_wv = 1;
      if (offset(dw_addr) == 0) begin
        m_resp = 2'b00;
        if (!m_done) begin m_done = 1; m_pass = (dw_data == 32'h01000001); end
      end else if (c >= 0) begin
        m_resp = 2'b00;
        if (dw_strobe[0]) q[c].push_back(dw_data[7:0]);
      end else begin
        m_resp = 2'b10;
      end
    end
    if (m_rv && dr_data_ready) m_rv = 0;
    if (ra) begin m_rv = 1; m_rdata = rv; end
    m_up = 1;
  endtask

  // Compare process: outputs at negedge, model advance at posedge.
  initial begin
    logic [N-1:0] ev;
    forever begin
      @(negedge clk);
      if (!rst) model_reset();
      check("w_ready", dw_data_addr_ready, m_wready());
      check("r_ready", dr_addr_ready, m_up && !m_rv);
      check("resp_valid", dw_resp_valid, m_wv);
      check("rdata_valid", dr_data_valid, m_rv);
      check("test_done", test_done, m_done);
      check("test_pass", test_pass, m_pass);
      if (m_wv) check("resp", dw_resp, m_resp);
      if (m_rv) check("rdata", dr_data, m_rdata);
      ev = '0;
      for (int k = 0; k < N; k++) begin
        ev[k] = q[k].size() > 0;
        if (ev[k]) check("tx_data", uart_tx_data[8*k +: 8], q[k][0]);
      end
      check("tx_valid", uart_tx_valid, ev);
      @(posedge clk);
      if (!rst) model_reset(); else model_step();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic [1:0] r);
    bit acc = 0, got = 0;
    dw_data_addr_valid = 1; dw_addr = a; dw_data = d; dw_strobe = s;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk); acc = dw_data_addr_ready; @(posedge clk); #1;
    end
    dw_data_addr_valid = 0;
    check("wr_accept", acc, 1);
    r = 2'bxx;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (dw_resp_valid) begin r = dw_resp; got = 1; end
      @(posedge clk); #1;
    end
    check("wr_resp_seen", got, 1);
  endtask

  task automatic rd_issue(input logic [31:0] a);
    bit acc = 0;
    dr_addr_valid = 1; dr_addr = a;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk); acc = dr_addr_ready; @(posedge clk); #1;
    end
    dr_addr_valid = 0;
    check("rd_accept", acc, 1);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bit got = 0;
    dr_data_ready = 1;
    rd_issue(a);
    d = 'x;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (dr_data_valid) begin d = dr_data; got = 1; end
      @(posedge clk); #1;
    end
    check("rd_data_seen", got, 1);
  endtask

  task automatic reset_pulse();
    rst = 0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  logic [1:0]  r;
  logic [31:0] d;
  logic [7:0]  got_b[5];
  int          nb;
  bit          wacc;
  logic [31:0] pool[8];

  initial begin
    @(negedge clk);
    check("rst_w_ready", dw_data_addr_ready, 0);
    check("rst_r_ready", dr_addr_ready, 0);
    check("rst_done", test_done, 0);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    dw_resp_ready = 1; dr_data_ready = 1;

    // PASS code, then a later write must not change the verdict
    wr(BASE, 32'h01000001, 4'hF, r);
    check("pass_resp", r, 2'b00);
    check("pass_done", test_done, 1);
    check("pass_pass", test_pass, 1);
    wr(BASE, 32'h0, 4'hF, r);
    check("second_resp", r, 2'b00);
    check("sticky_done", test_done, 1);
    check("sticky_pass", test_pass, 1);

    reset_pulse();
    wr(BASE, 32'h02000001, 4'hF, r);
    check("fail_done", test_done, 1);
    check("fail_pass", test_pass, 0);

    // Fill FIFO, stall the fifth byte, then drain in order
    uart_tx_ready = '0;
    for (int i = 0; i < 4; i++) begin
      wr(BASE + 4, 32'h41 + i, 4'h1, r);
      check("uart_resp", r, 2'b00);
    end
    dw_data_addr_valid = 1; dw_addr = BASE + 4; dw_data = 32'h45; dw_strobe = 4'h1;
    repeat (3) begin
      @(negedge clk); check("stall_ready", dw_data_addr_ready, 0); @(posedge clk); #1;
    end
    rd(BASE + 32'h40, d);
    check("status_full", d, 32'h00000100);
    check("model_status_full", m_status(), 32'h00000100);
    uart_tx_ready = '1;
    nb = 0;
    for (int cyc = 0; cyc < 40 && nb < 5; cyc++) begin
      @(negedge clk);
      if (uart_tx_valid[0]) begin got_b[nb] = uart_tx_data[7:0]; nb++; end
      wacc = dw_data_addr_valid && dw_data_addr_ready;
      @(posedge clk); #1;
      if (wacc) dw_data_addr_valid = 0;
    end
    check("uart_count", nb, 5);
    for (int i = 0; i < 5; i++) check("uart_byte", got_b[i], 32'h41 + i);

    // Unmapped offset
    wr(BASE + 32'h100, 32'h1234, 4'hF, r);
    check("unmapped_resp", r, 2'b10);
    rd(BASE + 32'h100, d);
    check("unmapped_rd", d, 32'hDEADBEEF);
    wr(BASE + 32'h40, 32'h1, 4'hF, r);
    check("ro_resp", r, 2'b10);

    // SYSCALL held with back-pressure; value sampled at acceptance
    syscall_in = 32'h1; dr_data_ready = 0;
    rd_issue(BASE + 32'h80);
    syscall_in = 32'h5;
    repeat (3) begin
      @(negedge clk);
      check("sys_valid", dr_data_valid, 1);
      check("sys_data", dr_data, SYS_EN ? 32'h1 : 32'hDEADBEEF);
      @(posedge clk); #1;
    end
    dr_data_ready = 1;
    @(posedge clk); #1;

    // Reset mid-transaction
    uart_tx_ready = '0; dw_resp_ready = 0;
    dw_data_addr_valid = 1; dw_addr = BASE + 4; dw_data = 32'h5A; dw_strobe = 4'h1;
    @(posedge clk); #1;
    dw_data_addr_valid = 0;
    @(negedge clk);
    check("pre_rst_resp_valid", dw_resp_valid, 1);
    check("pre_rst_tx_valid", uart_tx_valid, 1);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("rst_resp_valid", dw_resp_valid, 0);
    check("rst_resp", dw_resp, 0);
    check("rst_tx_valid", uart_tx_valid, 0);
    check("rst_tx_data", uart_tx_data, 0);
    check("rst_rdata_valid", dr_data_valid, 0);
    check("rst_rdata", dr_data, 0);
    check("rst_done2", test_done, 0);
    check("rst_pass2", test_pass, 0);
    check("rst_w_ready2", dw_data_addr_ready, 0);
    check("rst_r_ready2", dr_addr_ready, 0);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check("ready_after_rst", dw_data_addr_ready, 1);
    @(posedge clk); #1;
    dw_resp_ready = 1;
    rd(BASE + 32'h40, d);
    check("status_empty", d, 32'h00000001);

    // Randomized traffic
    pool = '{BASE, BASE + 4, BASE + 8, BASE + 32'h40, BASE + 32'h80,
             BASE + 32'h100, BASE + 32'h1000, BASE + 2};
    for (int i = 0; i < 3000; i++) begin
      dw_data_addr_valid = 1'($urandom);
      dw_addr   = pool[$urandom_range(0, 7)];
      dw_data   = ($urandom_range(0, 3) == 0) ? 32'h01000001 : $urandom;
      dw_strobe = 4'($urandom);
      dw_resp_ready = $urandom_range(0, 3) != 0;
      dr_addr_valid = 1'($urandom);
      dr_addr   = pool[$urandom_range(0, 7)];
      dr_data_ready = $urandom_range(0, 3) != 0;
      uart_tx_ready = N'($urandom_range(0, 2) == 0);
      syscall_in = $urandom;
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mmio_ctrl.md
MMIO_CTRL -- requirements
Module: mmio_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000, byte address of register window (4 KiB aligned).
REQ-002 SHALL have parameter UART_CHANNELS, default 1, range 1..8, number of TX byte channels.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, power of two >=2, per-channel TX FIFO entries.
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have write ports: dw_data_addr_valid in 1; dw_data_addr_ready out 1; dw_addr in BUS_WIDTH; dw_data in BUS_WIDTH; dw_strobe in BUS_WIDTH/8; dw_resp_valid out 1; dw_resp_ready in 1; dw_resp out BUS_RESP_WIDTH.
REQ-006 SHALL have read ports: dr_addr_valid in 1; dr_addr_ready out 1; dr_addr in BUS_WIDTH; dr_data_valid out 1; dr_data_ready in 1; dr_data out BUS_WIDTH.
REQ-007 SHALL have status ports: test_done out 1 sticky end-of-test; test_pass out 1 valid when test_done.
REQ-008 SHALL have UART ports: uart_tx_valid out UART_CHANNELS; uart_tx_ready in UART_CHANNELS; uart_tx_data out 8*UART_CHANNELS (channel k at [8k+7:8k]).
REQ-009 SHALL have syscall_in in BUS_WIDTH, value returned by syscall register.

Function
REQ-010 SHALL decode offsets from BASE_ADDR: 0x000 TEST (W), 0x004+4k UART_TX k (W), 0x040 UART_STATUS (R), 0x080 SYSCALL (R); anything else unmapped.
REQ-011 SHALL accept a write when dw_data_addr_valid && dw_data_addr_ready; ready low while a write response is pending or while a UART_TX write targets a full FIFO (stall, no drop).
REQ-012 SHALL assert dw_resp_valid the cycle after acceptance, holding dw_resp stable until dw_resp_ready; resp OKAY for mapped writes, ERROR for unmapped or read-only offsets.
REQ-013 SHALL, on TEST write of 32'h01000001, set test_done=1, test_pass=1; any other value sets test_done=1, test_pass=0; first write wins, later TEST writes ignored (still OKAY).
REQ-014 SHALL, on UART_TX k write with dw_strobe[0]=1, push dw_data[7:0] to FIFO k; strobe[0]=0 writes nothing, resp OKAY.
REQ-015 SHALL present FIFO k head as uart_tx_data k with uart_tx_valid[k]=!empty; pop on valid&&ready; push and pop same cycle on non-empty FIFO legal, occupancy unchanged.
REQ-016 SHALL accept a read when dr_addr_valid && dr_addr_ready; ready low while read data pending.
REQ-017 SHALL drive dr_data_valid the cycle after read acceptance, data held until dr_data_ready.
REQ-018 SHALL return UART_STATUS as bits[N-1:0]=FIFO empty, bits[8+N-1:8]=FIFO full, others 0.
REQ-019 SHALL return syscall_in sampled at read acceptance for SYSCALL, 32'hDEADBEEF for unmapped/write-only offsets.
REQ-020 SHALL handle read and write channels independently; simultaneous read and write both accepted same cycle.
REQ-021 SHALL compute FIFO pointers log2(FIFO_DEPTH)+1 bits wide, wrapping modulo 2*FIFO_DEPTH.

Reset
REQ-022 SHALL on rst low clear all FIFOs, test_done=0, test_pass=0, dw_resp_valid=0, dr_data_valid=0, uart_tx_valid=0, dw_resp=0, dr_data=0, ready outputs 0.
REQ-023 SHALL abandon pending responses on reset mid-transaction; ready outputs rise first cycle after rst release.

Configuration
REQ-024 SHALL with MMIO_SYSCALL_EN defined map SYSCALL at 0x080; without it 0x080 is unmapped (reads 32'hDEADBEEF) and syscall_in is unused.

Structure
REQ-025 SHALL place register offsets, PASS code 32'h01000001, resp codes OKAY/ERROR and 32'hDEADBEEF in shared package mmio_pkg.
REQ-026 SHALL implement per-channel FIFO as sub-module mmio_fifo, instantiated UART_CHANNELS times via generate.

Verification
REQ-027 SHALL test: write 32'h01000001 to 0x8000 -> test_done=1, test_pass=1, dw_resp OKAY; then write 0 -> flags unchanged.
REQ-028 SHALL test: write 32'h02000001 to 0x8000 -> test_done=1, test_pass=0.
REQ-029 SHALL test: uart_tx_ready[0]=0, write bytes 0x41..0x45 to 0x8004 with FIFO_DEPTH=4 -> fifth write stalls (ready=0), STATUS reads 32'h00000100; raise ready -> bytes 0x41..0x45 emerge in order.
REQ-030 SHALL test: write to 0x8100 -> dw_resp ERROR; read 0x8100 -> 32'hDEADBEEF.
REQ-031 SHALL test: syscall_in=1, read 0x8080 with dr_data_ready held low 3 cycles -> dr_data=1 stable throughout; without MMIO_SYSCALL_EN -> 32'hDEADBEEF.
REQ-032 SHALL test: assert rst low while dw_resp_valid=1 and FIFO non-empty -> all outputs at reset values, STATUS reads empty after release.
